clm_aes_host_ctrl: RTL

CLM_AES_HOST_CTRL -- requirements
Module: clm_aes_host_ctrl

---
 rtl/clm_aes_host_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/clm_aes_host_ctrl.sv
// Host-side sequencer for the CLM masked AES core: request capture, mask refill, launch, response.
// Optional WAIT watchdog is compiled in with `define CLM_HOST_TIMEOUT_EN.
module clm_aes_host_ctrl #(
  parameter int          D              = 4,
  parameter int          TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] SEED           = 32'hACE1_2468
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [127:0]    req_plaintext,
  input  logic [127:0]    req_key,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [127:0]    rsp_ciphertext,
  output logic            rsp_error,
  output logic [127:0]    core_plaintext,
  output logic [127:0]    core_key,
  output logic            core_drdy_i,
  input  logic            core_drdy_o,
  input  logic [127:0]    core_ciphertext,
  output logic [23*D-1:0] core_random_vect,
  input  logic            seed_load,
  input  logic [31:0]     seed_value,
  output logic            busy
);

  localparam int          RW       = 23 * D;
  localparam int          N        = (RW + 31) / 32;
  localparam int          CNTW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_LAUNCH,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [127:0]    pt_q, key_q, ct_q;
  logic [31:0]     lfsr_q, lfsr_nxt;
  logic [RW-1:0]   buf_q, buf_nxt;
  logic [CNTW-1:0] cnt_q;
  logic            accept, step, capture, reseed;

`ifdef CLM_HOST_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_q;
  logic           err_q;
  logic           wd_clr, timeout;
`endif

  // Galois right-shift step; the new word enters the low end of the mask buffer
  assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign buf_nxt  = RW'({buf_q, lfsr_nxt});

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    step        = 1'b0;
    capture     = 1'b0;
    reseed      = 1'b0;
`ifdef CLM_HOST_TIMEOUT_EN
    wd_clr      = 1'b0;
    timeout     = 1'b0;
`endif
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    core_drdy_i = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = rst;
        reseed    = seed_load;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        core_drdy_i = 1'b1;
`ifdef CLM_HOST_TIMEOUT_EN
        wd_clr      = 1'b1;
`endif
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (core_drdy_o) begin
          capture = 1'b1;
          state_d = S_RESPOND;
        end
`ifdef CLM_HOST_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = S_RESPOND;
        end
`endif
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pt_q   <= '0;
      key_q  <= '0;
      ct_q   <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      lfsr_q <= SEED;
    end else begin
      if (accept) begin
        pt_q  <= req_plaintext;
        key_q <= req_key;
        cnt_q <= '0;
      end
      if (reseed) lfsr_q <= (seed_value == 32'h0) ? SEED : seed_value;
      if (step) begin
        lfsr_q <= lfsr_nxt;
        buf_q  <= buf_nxt;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (capture) ct_q <= core_ciphertext;
`ifdef CLM_HOST_TIMEOUT_EN
      if (timeout) ct_q <= '0;
`endif
    end
  end

`ifdef CLM_HOST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wd_clr)                 wd_q <= '0;
      else if (state_q == S_WAIT) wd_q <= wd_q + 1'b1;
      if (capture)      err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  assign rsp_ciphertext   = ct_q;
  assign core_plaintext   = pt_q;
  assign core_key         = key_q;
  assign core_random_vect = buf_q;

endmodule
